// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_ctrl
// Purpose  : Register-bank controller between the SPI client and the on-chip
//            fabric. Decodes completed SPI read/write transactions into bank
//            accesses and shares the single bank port with a local requester.
//            The SPI side always wins the port.
// Ports    : clk, reset_n                   - clock, async active-low reset
//            reg_addr, addr_dv, rw_in       - SPI address, valid level, dir
//            rx_d, rxdv                     - SPI write data and valid level
//            tx_d, tx_en                    - SPI read data and its enable
//            loc_req/we/addr/wdata          - local access request
//            loc_gnt, loc_rdata, loc_rvalid - local grant and read return
//            spi_wr, ro_viol                - SPI write / read-only hit pulses
// Config   : SPI_REG_CTRL_RO_EN - when defined, addresses with the address MSB
//            set are read-only from SPI (writable from the local port).
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_ctrl #(
  parameter int ADDRSZ  = 7,
  parameter int PAYLOAD = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDRSZ-1:0]  reg_addr,
  input  logic               addr_dv,
  input  logic               rw_in,
  input  logic [PAYLOAD-1:0] rx_d,
  input  logic               rxdv,
  output logic [PAYLOAD-1:0] tx_d,
  output logic               tx_en,
  input  logic               loc_req,
  input  logic               loc_we,
  input  logic [ADDRSZ-1:0]  loc_addr,
  input  logic [PAYLOAD-1:0] loc_wdata,
  output logic               loc_gnt,
  output logic [PAYLOAD-1:0] loc_rdata,
  output logic               loc_rvalid,
  output logic               spi_wr,
  output logic               ro_viol
);

  localparam int c_depth = 1 << ADDRSZ;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_FETCH  = 3'd1,
    S_RD_HOLD   = 3'd2,
    S_WR_WAIT   = 3'd3,
    S_WR_COMMIT = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t             r_state;
  logic               r_addr_dv_q;
  logic               r_rxdv_q;
  logic [PAYLOAD-1:0] r_tx_d;
  logic               r_tx_en;
  logic               r_spi_wr;
  logic               r_ro_viol;
  logic [PAYLOAD-1:0] r_loc_rdata;
  logic               r_loc_rvalid;
  logic [PAYLOAD-1:0] r_bank [0:c_depth-1];

  logic w_dv_rise;
  logic w_rx_rise;
  logic w_spi_own;
  logic w_spi_we;
  logic w_loc_rd;
  logic w_ro_hit;

`ifdef SPI_REG_CTRL_RO_EN
  assign w_ro_hit = reg_addr[ADDRSZ-1];
`else
  assign w_ro_hit = 1'b0;
`endif

  assign w_dv_rise = addr_dv & ~r_addr_dv_q;
  assign w_rx_rise = rxdv & ~r_rxdv_q;

  // SPI holds the bank port only for its single fetch or commit cycle.
  assign w_spi_own = (r_state == S_RD_FETCH) || (r_state == S_WR_COMMIT);
  assign w_spi_we  = (r_state == S_WR_COMMIT) && !w_ro_hit;
  assign loc_gnt   = loc_req & ~w_spi_own;
  assign w_loc_rd  = loc_gnt & ~loc_we;

  // Transaction sequencer; all SPI-facing outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr_dv_q <= 1'b0;
      r_rxdv_q    <= 1'b0;
      r_tx_d      <= '0;
      r_tx_en     <= 1'b0;
      r_spi_wr    <= 1'b0;
      r_ro_viol   <= 1'b0;
    end else begin
      r_addr_dv_q <= addr_dv;
      r_rxdv_q    <= rxdv;
      r_spi_wr    <= 1'b0;
      r_ro_viol   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_dv_rise) r_state <= rw_in ? S_RD_FETCH : S_WR_WAIT;
        end
        S_RD_FETCH: begin
          r_tx_d  <= r_bank[reg_addr];
          r_state <= S_RD_HOLD;
        end
        S_RD_HOLD: begin
          // tx_en goes high one cycle after tx_d is loaded so the client
          // always samples settled data on the enable's rising edge.
          if (!addr_dv) begin
            r_tx_en <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tx_en <= 1'b1;
          end
        end
        S_WR_WAIT: begin
          // Losing addr_dv before data arrives is an aborted write.
          if (!addr_dv)       r_state <= S_IDLE;
          else if (w_rx_rise) r_state <= S_WR_COMMIT;
        end
        S_WR_COMMIT: begin
          if (w_ro_hit) r_ro_viol <= 1'b1;
          else          r_spi_wr  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!addr_dv) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bank write port: SPI commit and local writes never coincide because
  // the local grant is withheld during the commit cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < c_depth; i++) r_bank[i] <= '0;
    end else if (w_spi_we) begin
      r_bank[reg_addr] <= rx_d;
    end else if (loc_gnt && loc_we) begin
      r_bank[loc_addr] <= loc_wdata;
    end
  end

  // Local read return, one cycle after grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_loc_rdata  <= '0;
      r_loc_rvalid <= 1'b0;
    end else begin
      r_loc_rvalid <= w_loc_rd;
      if (w_loc_rd) r_loc_rdata <= r_bank[loc_addr];
    end
  end

  assign tx_d       = r_tx_d;
  assign tx_en      = r_tx_en;
  assign spi_wr     = r_spi_wr;
  assign ro_viol    = r_ro_viol;
  assign loc_rdata  = r_loc_rdata;
  assign loc_rvalid = r_loc_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_ctrl
// Purpose  : Directed self-checking bench for spi_reg_ctrl. Inputs change on
//            the falling clock edge; outputs are sampled on falling edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_ctrl;

  logic       clk;
  logic       reset_n;
  logic [6:0] reg_addr;
  logic       addr_dv;
  logic       rw_in;
  logic [7:0] rx_d;
  logic       rxdv;
  logic [7:0] tx_d;
  logic       tx_en;
  logic       loc_req;
  logic       loc_we;
  logic [6:0] loc_addr;
  logic [7:0] loc_wdata;
  logic       loc_gnt;
  logic [7:0] loc_rdata;
  logic       loc_rvalid;
  logic       spi_wr;
  logic       ro_viol;

  int vectors;
  int miscompares;

  spi_reg_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .reg_addr   (reg_addr),
    .addr_dv    (addr_dv),
    .rw_in      (rw_in),
    .rx_d       (rx_d),
    .rxdv       (rxdv),
    .tx_d       (tx_d),
    .tx_en      (tx_en),
    .loc_req    (loc_req),
    .loc_we     (loc_we),
    .loc_addr   (loc_addr),
    .loc_wdata  (loc_wdata),
    .loc_gnt    (loc_gnt),
    .loc_rdata  (loc_rdata),
    .loc_rvalid (loc_rvalid),
    .spi_wr     (spi_wr),
    .ro_viol    (ro_viol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  task automatic loc_write(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = a; loc_wdata = d;
    #1;
    vectors++;
    if (loc_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL loc_write_gnt addr=%h: got %b want 1", a, loc_gnt);
    end
    @(negedge clk);
    loc_req = 1'b0; loc_we = 1'b0;
  endtask

  task automatic loc_read(input logic [6:0] a, input logic [7:0] exp);
    @(negedge clk);
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = a;
    @(negedge clk);
    loc_req = 1'b0;
    vectors++;
    if (loc_rvalid !== 1'b1 || loc_rdata !== exp) begin
      miscompares++;
      $display("FAIL loc_read addr=%h: got rvalid=%b rdata=%h want 1/%h",
               a, loc_rvalid, loc_rdata, exp);
    end
    @(negedge clk);
    vectors++;
    if (loc_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL loc_rvalid_pulse addr=%h: got %b want 0", a, loc_rvalid);
    end
  endtask

  task automatic spi_read(input logic [6:0] a, input logic [7:0] exp);
    @(negedge clk);
    reg_addr = a; rw_in = 1'b1; addr_dv = 1'b1;
    @(negedge clk);                 // state now RD_FETCH
    vectors++;
    if (tx_en !== 1'b0) begin
      miscompares++;
      $display("FAIL spi_read_en_early addr=%h: got %b want 0", a, tx_en);
    end
    @(negedge clk);                 // tx_d loaded, tx_en not yet
    vectors++;
    if (tx_d !== exp || tx_en !== 1'b0) begin
      miscompares++;
      $display("FAIL spi_read_load addr=%h: got tx_d=%h tx_en=%b want %h/0",
               a, tx_d, tx_en, exp);
    end
    @(negedge clk);                 // tx_en rises
    vectors++;
    if (tx_en !== 1'b1) begin
      miscompares++;
      $display("FAIL spi_read_en addr=%h: got %b want 1", a, tx_en);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (tx_en !== 1'b1 || tx_d !== exp) begin
      miscompares++;
      $display("FAIL spi_read_hold addr=%h: got tx_d=%h tx_en=%b want %h/1",
               a, tx_d, tx_en, exp);
    end
    addr_dv = 1'b0;
    @(negedge clk);
    vectors++;
    if (tx_en !== 1'b0 || tx_d !== exp) begin
      miscompares++;
      $display("FAIL spi_read_end addr=%h: got tx_d=%h tx_en=%b want %h/0",
               a, tx_d, tx_en, exp);
    end
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d,
                           input logic exp_wr, input logic exp_ro);
    @(negedge clk);
    reg_addr = a; rw_in = 1'b0; addr_dv = 1'b1;
    @(negedge clk);                 // WR_WAIT
    rx_d = d; rxdv = 1'b1;
    @(negedge clk);                 // WR_COMMIT
    vectors++;
    if (spi_wr !== 1'b0 || ro_viol !== 1'b0) begin
      miscompares++;
      $display("FAIL spi_write_early addr=%h: got wr=%b ro=%b want 0/0",
               a, spi_wr, ro_viol);
    end
    @(negedge clk);                 // DONE, pulse visible
    vectors++;
    if (spi_wr !== exp_wr || ro_viol !== exp_ro) begin
      miscompares++;
      $display("FAIL spi_write_pulse addr=%h: got wr=%b ro=%b want %b/%b",
               a, spi_wr, ro_viol, exp_wr, exp_ro);
    end
    @(negedge clk);
    vectors++;
    if (spi_wr !== 1'b0 || ro_viol !== 1'b0) begin
      miscompares++;
      $display("FAIL spi_write_width addr=%h: got wr=%b ro=%b want 0/0",
               a, spi_wr, ro_viol);
    end
    rxdv = 1'b0; addr_dv = 1'b0;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset_n = 1'b0;
    reg_addr = '0; addr_dv = 1'b0; rw_in = 1'b0; rx_d = '0; rxdv = 1'b0;
    loc_req = 1'b0; loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({tx_d, tx_en, loc_rdata, loc_rvalid, spi_wr, ro_viol, loc_gnt} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got tx_d=%h tx_en=%b rdata=%h rvalid=%b wr=%b ro=%b gnt=%b want all 0",
               tx_d, tx_en, loc_rdata, loc_rvalid, spi_wr, ro_viol, loc_gnt);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_local_then_spi_read();
    loc_write(7'h03, 8'h5A);
    spi_read(7'h03, 8'h5A);
    spi_read(7'h04, 8'h00);
  endtask

  task automatic test_spi_write();
    spi_write(7'h10, 8'hC3, 1'b1, 1'b0);
    loc_read(7'h10, 8'hC3);
  endtask

  task automatic test_priority();
    @(negedge clk);                 // N0: IDLE
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 7'h10;
    reg_addr = 7'h20; rw_in = 1'b0; addr_dv = 1'b1;
    #1;
    vectors++;
    if (loc_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_gnt_idle: got %b want 1", loc_gnt);
    end
    @(negedge clk);                 // N1: WR_WAIT
    vectors++;
    if (loc_gnt !== 1'b1 || loc_rvalid !== 1'b1 || loc_rdata !== 8'hC3) begin
      miscompares++;
      $display("FAIL prio_wait: got gnt=%b rvalid=%b rdata=%h want 1/1/c3",
               loc_gnt, loc_rvalid, loc_rdata);
    end
    rx_d = 8'h77; rxdv = 1'b1;
    @(negedge clk);                 // N2: WR_COMMIT
    vectors++;
    if (loc_gnt !== 1'b0 || loc_rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_commit: got gnt=%b rvalid=%b want 0/1", loc_gnt, loc_rvalid);
    end
    @(negedge clk);                 // N3: DONE
    vectors++;
    if (loc_gnt !== 1'b1 || loc_rvalid !== 1'b0 || spi_wr !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_done: got gnt=%b rvalid=%b wr=%b want 1/0/1",
               loc_gnt, loc_rvalid, spi_wr);
    end
    @(negedge clk);
    vectors++;
    if (loc_gnt !== 1'b1 || loc_rvalid !== 1'b1 || loc_rdata !== 8'hC3) begin
      miscompares++;
      $display("FAIL prio_resume: got gnt=%b rvalid=%b rdata=%h want 1/1/c3",
               loc_gnt, loc_rvalid, loc_rdata);
    end
    loc_req = 1'b0; addr_dv = 1'b0; rxdv = 1'b0;
    @(negedge clk);
    spi_read(7'h20, 8'h77);
  endtask

  task automatic test_abort();
    @(negedge clk);
    reg_addr = 7'h03; rw_in = 1'b0; addr_dv = 1'b1; rx_d = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (spi_wr !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_wait_wr cycle %0d: got %b want 0", i, spi_wr);
      end
    end
    addr_dv = 1'b0;
    @(negedge clk);
    rxdv = 1'b1;                    // late data must be ignored in IDLE
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (spi_wr !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_late_wr cycle %0d: got %b want 0", i, spi_wr);
      end
    end
    rxdv = 1'b0;
    loc_read(7'h03, 8'h5A);
    spi_read(7'h03, 8'h5A);
  endtask

  task automatic test_read_only();
`ifdef SPI_REG_CTRL_RO_EN
    spi_write(7'h40, 8'hFF, 1'b0, 1'b1);
    loc_read(7'h40, 8'h00);
    loc_write(7'h40, 8'h12);
    loc_read(7'h40, 8'h12);
`else
    spi_write(7'h40, 8'hFF, 1'b1, 1'b0);
    loc_read(7'h40, 8'hFF);
`endif
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = 7'h05; loc_wdata = 8'h11;
    @(negedge clk);
    loc_addr = 7'h06; loc_wdata = 8'h22;
    @(negedge clk);
    loc_addr = 7'h07; loc_wdata = 8'h33;
    @(negedge clk);
    loc_we = 1'b0; loc_addr = 7'h05;
    @(negedge clk);
    vectors++;
    if (loc_rvalid !== 1'b1 || loc_rdata !== 8'h11) begin
      miscompares++;
      $display("FAIL b2b_rd0: got rvalid=%b rdata=%h want 1/11", loc_rvalid, loc_rdata);
    end
    loc_addr = 7'h06;
    @(negedge clk);
    vectors++;
    if (loc_rvalid !== 1'b1 || loc_rdata !== 8'h22) begin
      miscompares++;
      $display("FAIL b2b_rd1: got rvalid=%b rdata=%h want 1/22", loc_rvalid, loc_rdata);
    end
    loc_addr = 7'h07;
    @(negedge clk);
    vectors++;
    if (loc_rvalid !== 1'b1 || loc_rdata !== 8'h33) begin
      miscompares++;
      $display("FAIL b2b_rd2: got rvalid=%b rdata=%h want 1/33", loc_rvalid, loc_rdata);
    end
    loc_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (loc_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: got rvalid=%b want 0", loc_rvalid);
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    reg_addr = 7'h10; rw_in = 1'b1; addr_dv = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (tx_en !== 1'b1 || tx_d !== 8'hC3) begin
      miscompares++;
      $display("FAIL rst_pre_hold: got tx_d=%h tx_en=%b want c3/1", tx_d, tx_en);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (tx_en !== 1'b0 || tx_d !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_async: got tx_d=%h tx_en=%b want 00/0", tx_d, tx_en);
    end
    addr_dv = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    spi_read(7'h10, 8'h00);
    loc_read(7'h03, 8'h00);
    loc_read(7'h20, 8'h00);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_local_then_spi_read();
    test_spi_write();
    test_priority();
    test_abort();
    test_read_only();
    test_back_to_back();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Register-bank controller between the SPI client and the on-chip fabric. It decodes completed SPI write and read transactions into accesses to an internal register bank, and returns read data to the SPI client for shifting out on MISO. It also shares the single bank port with a local requester, and the SPI side always has priority.

## Interface
Parameters:
- `addrsz`, 7, register address width; bank depth is 2**`addrsz`.
- `payload`, 8, register data width.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `reg_addr`  in  `addrsz`  SPI register address from the SPI client
- `addr_dv`  in  1  SPI address valid; level, high until end of transaction
- `rw_in`  in  1  SPI direction: 1 = read, 0 = write
- `rx_d`  in  `payload`  SPI write data
- `rxdv`  in  1  SPI write data valid; level
- `tx_d`  out  `payload`  read data to the SPI client
- `tx_en`  out  1  read data enable to the SPI client; its rising edge loads `tx_d`
- `loc_req`  in  1  local access request
- `loc_we`  in  1  local write (1) or read (0)
- `loc_addr`  in  `addrsz`  local address
- `loc_wdata`  in  `payload`  local write data
- `loc_gnt`  out  1  local request accepted this cycle
- `loc_rdata`  out  `payload`  local read data
- `loc_rvalid`  out  1  one-cycle pulse; `loc_rdata` valid
- `spi_wr`  out  1  one-cycle pulse when an SPI write commits
- `ro_viol`  out  1  one-cycle pulse when an SPI write hits a read-only address

## Operation
- `addr_dv_q` and `rxdv_q` are registered copies of the inputs. `dv_rise = addr_dv & ~addr_dv_q`; `rx_rise = rxdv & ~rxdv_q`.
- State machine `IDLE`, `RD_FETCH`, `RD_HOLD`, `WR_WAIT`, `WR_COMMIT`, `DONE`:
  - `IDLE`: on `dv_rise` go to `RD_FETCH` if `rw_in`=1, else to `WR_WAIT`.
  - `RD_FETCH`: `tx_d <= bank[reg_addr]`; go to `RD_HOLD`.
  - `RD_HOLD`: `tx_en`=1. When `addr_dv`=0, clear `tx_en` and go to `IDLE`.
  - `WR_WAIT`: on `rx_rise` go to `WR_COMMIT`. If `addr_dv`=0 first (aborted transaction), go to `IDLE` with no write.
  - `WR_COMMIT`: `bank[reg_addr] <= rx_d`; pulse `spi_wr`; go to `DONE`.
  - `DONE`: when `addr_dv`=0, go to `IDLE`.
- Bank port ownership:
  - SPI owns the port in `RD_FETCH` and `WR_COMMIT`.
  - Otherwise `loc_gnt = loc_req` (combinational). Writes update the bank at that clock edge; reads register `loc_rdata` and pulse `loc_rvalid` on the next cycle.
- Simultaneous events:
  - In an SPI-owned cycle `loc_gnt`=0, and the requester holds its request.
  - A local write and an SPI read of the same address are never in the same cycle. SPI reads the value as of `RD_FETCH`.
- `tx_d` holds its value until the next `RD_FETCH`.
- Reset (at any time, including mid-transaction):
  - state `IDLE`; all bank entries 0; `tx_d`=0, `tx_en`=0; `loc_rdata`=0, `loc_rvalid`=0; `spi_wr`=0, `ro_viol`=0.
  - `loc_gnt` is 0 while `loc_req`=0.

## Timing
- `dv_rise` is detected 1 clk after `addr_dv` rises.
- `tx_d` is loaded 2 clk after `addr_dv` rises; `tx_en` rises 3 clk after.
- The SPI client then synchronises `tx_en` in 2 more clk. The SCLK half-period must therefore be at least 6 clk.
- `spi_wr` pulses 2 clk after `rxdv` rises.
- Local read latency is 1 clk from grant to `loc_rvalid`. Local throughput is 1 access/clk when not blocked.
- SPI blocks the local port for at most 1 cycle per SPI transaction.

## Configuration
- `SPI_REG_CTRL_RO_EN` defined:
  - Addresses with MSB (`reg_addr[addrsz-1]`) = 1 are read-only from SPI.
  - `WR_COMMIT` skips the bank write, pulses `ro_viol` instead of `spi_wr`, then goes to `DONE`.
  - The local port may still write these addresses.
- Undefined: all addresses are SPI-writable, and `ro_viol` is tied 0.

## Test plan
- Local write 0x5A to addr 0x03, then SPI read of 0x03 -> `tx_d`=0x5A, `tx_en` high until `addr_dv` falls, then 0.
- SPI write 0xC3 to addr 0x10 -> one `spi_wr` pulse; a following local read of 0x10 -> `loc_rdata`=0xC3 with a one-cycle `loc_rvalid`.
- `loc_req` held high continuously during an SPI write -> `loc_gnt` low exactly in the `WR_COMMIT` cycle; every other local access completes.
- `addr_dv` drops in `WR_WAIT` before `rxdv` -> no bank change, no `spi_wr`, state returns to `IDLE`.
- With `SPI_REG_CTRL_RO_EN`, SPI write 0xFF to 0x40 -> `ro_viol` pulses, bank[0x40] is unchanged; without the macro -> bank[0x40]=0xFF.
- Assert `reset_n` during `RD_HOLD` -> `tx_en`=0 and bank cleared immediately; the next SPI read returns 0x00.
